// File: rtl/mshr_refill_ctrl.sv
// Refill response controller: matches link responses to MSHR entries by trans_id,
// assembles the line, issues one cache fill and then frees the MSHR entry.
//
// state     | meaning
// S_IDLE    | waiting for the first beat of a response
// S_COLLECT | storing beats of a matched response
// S_DRAIN   | discarding an orphan response up to rsp_last
// S_FILL    | presenting the assembled line to the cache
// S_FREE    | one-cycle deallocate pulse to the MSHR
module mshr_refill_ctrl #(
    parameter int MSHR_ENTRIES   = 8,
    parameter int DATA_WIDTH     = 64,
    parameter int LINE_BEATS     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int TRANS_ID_WIDTH = 8,
    localparam int EW = $clog2(MSHR_ENTRIES),
    localparam int LW = DATA_WIDTH * LINE_BEATS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_rsp_valid,
    output logic                                 o_rsp_ready,
    input  logic [TRANS_ID_WIDTH-1:0]            i_rsp_trans_id,
    input  logic [DATA_WIDTH-1:0]                i_rsp_data,
    input  logic                                 i_rsp_last,
    input  logic                                 i_rsp_err,
    input  logic [MSHR_ENTRIES-1:0]              i_entry_valid,
    input  logic [MSHR_ENTRIES*ADDR_WIDTH-1:0]   i_entry_addr,
    input  logic [MSHR_ENTRIES*TRANS_ID_WIDTH-1:0] i_entry_trans_id,
    output logic                                 o_fill_valid,
    input  logic                                 i_fill_ready,
    output logic [ADDR_WIDTH-1:0]                o_fill_addr,
    output logic [LW-1:0]                        o_fill_data,
    output logic                                 o_dealloc,
    output logic [EW-1:0]                        o_dealloc_entry,
    output logic                                 o_err_valid,
    output logic [TRANS_ID_WIDTH-1:0]            o_err_trans_id
);

    localparam int BCW = $clog2(LINE_BEATS) + 1;
    localparam logic [BCW-1:0] LAST_CNT = BCW'(LINE_BEATS - 1);
    localparam logic [BCW-1:0] FULL_CNT = BCW'(LINE_BEATS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_FILL,
        S_FREE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_live;
    logic [BCW-1:0]            r_beat_cnt;
    logic                      r_err_seen;
    logic [EW-1:0]             r_idx;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [TRANS_ID_WIDTH-1:0] r_tid;
    logic [LW-1:0]             r_line;
    logic                      r_err_valid;
    logic [TRANS_ID_WIDTH-1:0] r_err_id;

    logic                      w_hit;
    logic [EW-1:0]             w_hit_idx;
    logic [ADDR_WIDTH-1:0]     w_hit_addr;
    logic                      w_rsp_ready;
    logic                      w_accept;
    logic                      w_capture;
    logic                      w_store;
    logic [BCW-1:0]            w_store_slot;
    logic                      w_err_set;
    logic [TRANS_ID_WIDTH-1:0] w_err_id;
    logic                      w_bad;

    // Scan from the top down so the lowest matching entry is the one left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_hit_addr = '0;
        for (int i = MSHR_ENTRIES - 1; i >= 0; i--) begin
            if (i_entry_valid[i] &&
                i_entry_trans_id[i*TRANS_ID_WIDTH +: TRANS_ID_WIDTH] == i_rsp_trans_id) begin
                w_hit      = 1'b1;
                w_hit_idx  = EW'(i);
                w_hit_addr = i_entry_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign w_accept = i_rsp_valid & w_rsp_ready;
    assign w_bad    = r_err_seen | i_rsp_err | (r_beat_cnt != LAST_CNT);

    always_comb begin
        w_state_nxt  = r_state;
        w_rsp_ready  = 1'b0;
        o_fill_valid = 1'b0;
        o_dealloc    = 1'b0;
        w_capture    = 1'b0;
        w_store      = 1'b0;
        w_store_slot = r_beat_cnt;
        w_err_set    = 1'b0;
        w_err_id     = r_tid;
        case (r_state)
            S_IDLE: begin
                w_rsp_ready = r_live;
                if (w_accept) begin
                    if (!w_hit) begin
                        w_err_set   = 1'b1;
                        w_err_id    = i_rsp_trans_id;
                        w_state_nxt = i_rsp_last ? S_IDLE : S_DRAIN;
                    end else begin
                        w_capture    = 1'b1;
                        w_store      = 1'b1;
                        w_store_slot = '0;
                        if (i_rsp_last) begin
                            // a single-beat line is always short
                            w_err_set   = 1'b1;
                            w_err_id    = i_rsp_trans_id;
                            w_state_nxt = S_FREE;
                        end else begin
                            w_state_nxt = S_COLLECT;
                        end
                    end
                end
            end
            S_COLLECT: begin
                w_rsp_ready = 1'b1;
                if (w_accept) begin
                    w_store = (r_beat_cnt < FULL_CNT);
                    if (i_rsp_last) begin
                        if (w_bad) begin
                            w_err_set   = 1'b1;
                            w_state_nxt = S_FREE;
                        end else begin
                            w_state_nxt = S_FILL;
                        end
                    end
                end
            end
            S_DRAIN: begin
                w_rsp_ready = 1'b1;
                if (w_accept && i_rsp_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FILL: begin
                o_fill_valid = 1'b1;
                if (i_fill_ready) begin
                    w_state_nxt = S_FREE;
                end
            end
            S_FREE: begin
                o_dealloc   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_live      <= 1'b0;
            r_beat_cnt  <= '0;
            r_err_seen  <= 1'b0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_tid       <= '0;
            r_line      <= '0;
            r_err_valid <= 1'b0;
            r_err_id    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_live      <= 1'b1;
            r_err_valid <= w_err_set;
            if (w_err_set) begin
                r_err_id <= w_err_id;
            end
            if (w_capture) begin
                r_idx      <= w_hit_idx;
                r_addr     <= w_hit_addr;
                r_tid      <= i_rsp_trans_id;
                r_err_seen <= i_rsp_err;
                r_beat_cnt <= BCW'(1);
            end else if (r_state == S_COLLECT && w_accept) begin
                r_err_seen <= r_err_seen | i_rsp_err;
                // saturate at LINE_BEATS; an overrun stays a length mismatch until rsp_last
                if (r_beat_cnt != FULL_CNT) begin
                    r_beat_cnt <= r_beat_cnt + BCW'(1);
                end
            end else if (r_state == S_FREE) begin
                r_beat_cnt <= '0;
                r_err_seen <= 1'b0;
            end
            if (w_store) begin
                for (int b = 0; b < LINE_BEATS; b++) begin
                    if (w_store_slot == BCW'(b)) begin
                        r_line[b*DATA_WIDTH +: DATA_WIDTH] <= i_rsp_data;
                    end
                end
            end
        end
    end

    assign o_rsp_ready     = w_rsp_ready;
    assign o_fill_addr     = r_addr;
    assign o_fill_data     = r_line;
    assign o_dealloc_entry = o_dealloc ? r_idx : '0;
    assign o_err_valid     = r_err_valid;
    assign o_err_trans_id  = r_err_id;

endmodule

// File: tb/tb_mshr_refill_ctrl.sv
// Testbench for mshr_refill_ctrl: directed and random responses checked against a
// per-response model of expected fill, deallocate and error outcomes.
module tb_mshr_refill_ctrl;

    localparam int NE = 8;
    localparam int DW = 64;
    localparam int LB = 4;
    localparam int AW = 32;
    localparam int TW = 8;
    localparam int EW = 3;
    localparam int LW = DW * LB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  i_rsp_valid = 1'b0;
    logic                  o_rsp_ready;
    logic [TW-1:0]         i_rsp_trans_id = '0;
    logic [DW-1:0]         i_rsp_data = '0;
    logic                  i_rsp_last = 1'b0;
    logic                  i_rsp_err = 1'b0;
    logic [NE-1:0]         i_entry_valid;
    logic [NE*AW-1:0]      i_entry_addr;
    logic [NE*TW-1:0]      i_entry_trans_id;
    logic                  o_fill_valid;
    logic                  i_fill_ready = 1'b1;
    logic [AW-1:0]         o_fill_addr;
    logic [LW-1:0]         o_fill_data;
    logic                  o_dealloc;
    logic [EW-1:0]         o_dealloc_entry;
    logic                  o_err_valid;
    logic [TW-1:0]         o_err_trans_id;

    logic          ev [NE];
    logic [AW-1:0] ea [NE];
    logic [TW-1:0] et [NE];

    always_comb begin
        for (int i = 0; i < NE; i++) begin
            i_entry_valid[i]              = ev[i];
            i_entry_addr[i*AW +: AW]      = ea[i];
            i_entry_trans_id[i*TW +: TW]  = et[i];
        end
    end

    mshr_refill_ctrl #(
        .MSHR_ENTRIES(NE), .DATA_WIDTH(DW), .LINE_BEATS(LB),
        .ADDR_WIDTH(AW), .TRANS_ID_WIDTH(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_rsp_valid(i_rsp_valid), .o_rsp_ready(o_rsp_ready),
        .i_rsp_trans_id(i_rsp_trans_id), .i_rsp_data(i_rsp_data),
        .i_rsp_last(i_rsp_last), .i_rsp_err(i_rsp_err),
        .i_entry_valid(i_entry_valid), .i_entry_addr(i_entry_addr),
        .i_entry_trans_id(i_entry_trans_id),
        .o_fill_valid(o_fill_valid), .i_fill_ready(i_fill_ready),
        .o_fill_addr(o_fill_addr), .o_fill_data(o_fill_data),
        .o_dealloc(o_dealloc), .o_dealloc_entry(o_dealloc_entry),
        .o_err_valid(o_err_valid), .o_err_trans_id(o_err_trans_id)
    );

    // Event recorder: values seen during the cycle that each posedge closes.
    int            cyc = 0;
    int            n_fill = 0, n_dea = 0, n_err = 0;
    logic [AW-1:0] m_fill_addr = '0;
    logic [LW-1:0] m_fill_data = '0;
    int            m_fill_cyc = 0, m_rise_cyc = 0, m_dea_cyc = 0, m_err_cyc = 0;
    int            m_first_cyc = 0, m_last_cyc = 0;
    logic [EW-1:0] m_dea_entry = '0;
    logic [TW-1:0] m_err_id = '0;
    logic          prev_fv = 1'b0;
    logic          in_rsp = 1'b0;

    always @(posedge clk) begin
        prev_fv <= o_fill_valid;
        if (o_fill_valid && !prev_fv) m_rise_cyc <= cyc;
        if (o_fill_valid && i_fill_ready) begin
            n_fill      <= n_fill + 1;
            m_fill_addr <= o_fill_addr;
            m_fill_data <= o_fill_data;
            m_fill_cyc  <= cyc;
        end
        if (o_dealloc) begin
            n_dea       <= n_dea + 1;
            m_dea_entry <= o_dealloc_entry;
            m_dea_cyc   <= cyc;
        end
        if (o_err_valid) begin
            n_err     <= n_err + 1;
            m_err_id  <= o_err_trans_id;
            m_err_cyc <= cyc;
        end
        if (!rst_n) begin
            in_rsp <= 1'b0;
        end else if (i_rsp_valid && o_rsp_ready) begin
            if (!in_rsp) m_first_cyc <= cyc;
            if (i_rsp_last) m_last_cyc <= cyc;
            in_rsp <= !i_rsp_last;
        end
        cyc <= cyc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int g_prev_fill = -1;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_beat(input logic [TW-1:0] id, input logic [DW-1:0] d,
                              input logic e, input logic l);
        int t;
        i_rsp_valid    = 1'b1;
        i_rsp_trans_id = id;
        i_rsp_data     = d;
        i_rsp_err      = e;
        i_rsp_last     = l;
        t = 0;
        while (!o_rsp_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("beat_accept", t < 200, 1);
        @(negedge clk);
    endtask

    // One whole response; the expectation comes from the lookup/length/error rules.
    task automatic run_rsp(input logic [TW-1:0] id, input int nb, input logic [7:0] emask,
                           input int stall);
        logic          hit, good, anyerr;
        int            idx, f0, d0, e0, t;
        logic [LW-1:0] line;
        logic [DW-1:0] d;
        hit = 1'b0; idx = 0; anyerr = 1'b0; line = '0;
        for (int i = 0; i < NE; i++) begin
            if (!hit && ev[i] && et[i] == id) begin
                hit = 1'b1;
                idx = i;
            end
        end
        for (int b = 0; b < nb; b++) anyerr |= emask[b];
        good = hit && (nb == LB) && !anyerr;
        f0 = n_fill; d0 = n_dea; e0 = n_err;
        if (good && stall > 0) i_fill_ready = 1'b0;

        for (int b = 0; b < nb; b++) begin
            d = {$urandom, $urandom};
            if (b < LB) line[b*DW +: DW] = d;
            drive_beat((b == 0) ? id : TW'($urandom), d, emask[b], b == nb - 1);
        end
        i_rsp_valid = 1'b0;
        i_rsp_last  = 1'b0;
        i_rsp_err   = 1'b0;

        if (good && stall > 0) begin
            for (int s = 0; s < stall; s++) begin
                check("stall_fill_valid", o_fill_valid, 1);
                check("stall_fill_addr", o_fill_addr, ea[idx]);
                check("stall_fill_data", o_fill_data, line);
                check("stall_rsp_ready", o_rsp_ready, 0);
                // a waiting response must not be taken while the fill is pending
                i_rsp_valid    = 1'b1;
                i_rsp_trans_id = id;
                i_rsp_data     = {$urandom, $urandom};
                @(negedge clk);
            end
            i_fill_ready = 1'b1;
            @(negedge clk);
            i_rsp_valid = 1'b0;
        end

        t = 0;
        while (!(o_rsp_ready && !o_fill_valid && !o_dealloc) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rsp_complete", t < 50, 1);
        @(negedge clk);
        @(negedge clk);

        if (g_prev_fill >= 0) check("accept_gap", m_first_cyc >= g_prev_fill + 2, 1);
        check("fill_count", n_fill - f0, good ? 1 : 0);
        check("dealloc_count", n_dea - d0, hit ? 1 : 0);
        check("err_count", n_err - e0, good ? 0 : 1);
        if (good) begin
            check("fill_addr", m_fill_addr, ea[idx]);
            check("fill_data", m_fill_data, line);
            check("fill_latency", m_rise_cyc, m_last_cyc + 1);
            check("dealloc_after_fill", m_dea_cyc, m_fill_cyc + 1);
            g_prev_fill = m_fill_cyc;
        end
        if (hit) check("dealloc_entry", m_dea_entry, idx);
        if (hit && !good) check("dealloc_after_bad", m_dea_cyc, m_last_cyc + 1);
        if (!good) begin
            check("err_trans_id", m_err_id, id);
            check("err_latency", m_err_cyc, (hit ? m_last_cyc : m_first_cyc) + 1);
        end
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_rsp_ready"}, o_rsp_ready, 0);
        check({tag, "_fill_valid"}, o_fill_valid, 0);
        check({tag, "_dealloc"}, o_dealloc, 0);
        check({tag, "_err_valid"}, o_err_valid, 0);
        check({tag, "_fill_addr"}, o_fill_addr, 0);
        check({tag, "_fill_data"}, o_fill_data, 0);
        check({tag, "_dealloc_entry"}, o_dealloc_entry, 0);
        check({tag, "_err_trans_id"}, o_err_trans_id, 0);
    endtask

    initial begin
        int r, nb, stall, dea0, fill0;
        logic [7:0] emask;
        for (int i = 0; i < NE; i++) begin
            ev[i] = 1'b0; ea[i] = '0; et[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_outputs_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        ev[2] = 1'b1; et[2] = 8'h15; ea[2] = 32'h1000;
        run_rsp(8'h15, 4, 8'h00, 0);
        run_rsp(8'h7F, 4, 8'h00, 0);
        run_rsp(8'h15, 4, 8'h02, 0);
        run_rsp(8'h15, 3, 8'h00, 0);
        run_rsp(8'h15, 5, 8'h00, 0);
        run_rsp(8'h15, 4, 8'h00, 10);
        run_rsp(8'h15, 4, 8'h00, 0);
        ev[6] = 1'b1; et[6] = 8'h15; ea[6] = 32'h2000;
        run_rsp(8'h15, 4, 8'h00, 0);
        run_rsp(8'h15, 1, 8'h00, 0);

        // reset in the middle of a response
        dea0 = n_dea; fill0 = n_fill;
        drive_beat(8'h15, 64'h1111, 1'b0, 1'b0);
        drive_beat(8'h15, 64'h2222, 1'b0, 1'b0);
        rst_n = 1'b0;
        i_rsp_valid = 1'b0;
        #1;
        check_outputs_idle("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midreset_no_dealloc", n_dea - dea0, 0);
        check("midreset_no_fill", n_fill - fill0, 0);
        g_prev_fill = -1;
        run_rsp(8'h15, 4, 8'h00, 0);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < NE; i++) begin
                ev[i] = 1'($urandom_range(0, 1));
                et[i] = TW'($urandom_range(0, 7));
                ea[i] = {$urandom} & 32'hFFFF_FFE0;
            end
            r = $urandom_range(0, 9);
            nb = (r < 6) ? 4 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 5;
            emask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_rsp(TW'($urandom_range(0, 9)), nb, emask, stall);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
